// File: rtl/data_memory_sized.sv
// Word-organised data memory with byte/halfword/word access, fixed wait states and misalignment rejection.
// Optional macro DMEM_RESET_CLEAR_EN zeroes the whole array while rst is held.
module data_memory_sized #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        write_control,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] mem_data,
  output logic        ready,
  output logic        misalign
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [3:0]    cnt_r;
  logic [AW-1:0] addr_r;
  logic [1:0]    size_r;
  logic          write_r;
  logic          uns_r;
  logic          err_r;
  logic [31:0]   wdata_r;
  logic [31:0]   mem [WORDS];
  logic          illegal_s;
  logic          mem_we_s;
  logic [31:0]   rd_word_s;
  logic          unused_s;

  function automatic logic access_illegal(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      2'b10:   return (lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] data,
                                              input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] r;
    r = old;
    case (sz)
      2'b00:   r[{lane, 3'b000} +: 8] = data[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = data[15:0];
      2'b10:   r = data;
      default: r = old;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   return uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  assign illegal_s = access_illegal(size, address[1:0]);
  assign mem_we_s  = (state_r == DONE) && write_r && !err_r;
  assign rd_word_s = mem[addr_r[AW-1:2]];
  // Address bits above the array size are deliberately ignored (wrap-around).
  assign unused_s  = ^address[31:AW];

  // Next-state decode; illegal requests skip the wait phase.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          if (illegal_s || (WAIT_CYCLES == 32'sd0)) begin
            state_s = DONE;
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch, wait counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= 4'd0;
      addr_r   <= '0;
      size_r   <= 2'b00;
      write_r  <= 1'b0;
      uns_r    <= 1'b0;
      err_r    <= 1'b0;
      wdata_r  <= 32'd0;
      mem_data <= 32'd0;
      ready    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      ready    <= (state_r == DONE);
      misalign <= (state_r == DONE) && err_r;
      if (state_r == IDLE && req) begin
        addr_r  <= address[AW-1:0];
        size_r  <= size;
        write_r <= write_control;
        uns_r   <= load_unsigned;
        err_r   <= illegal_s;
        wdata_r <= wdata;
        cnt_r   <= (WAIT_CYCLES > 32'sd0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
      end else if (state_r == WAIT && cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (state_r == DONE && !err_r && !write_r) begin
        mem_data <= load_extract(rd_word_s, size_r, addr_r[1:0], uns_r);
      end
    end
  end

  // Storage array; a reset in the same cycle as DONE suppresses the write.
  always_ff @(posedge clk) begin
`ifdef DMEM_RESET_CLEAR_EN
    if (rst) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (mem_we_s) begin
      mem[addr_r[AW-1:2]] <= store_merge(rd_word_s, wdata_r, size_r, addr_r[1:0]);
    end
`else
    if (!rst && mem_we_s) begin
      mem[addr_r[AW-1:2]] <= store_merge(rd_word_s, wdata_r, size_r, addr_r[1:0]);
    end
`endif
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Randomised bench for data_memory_sized against a byte-array reference model
// (one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=0).
module tb_data_memory_sized;

  logic        clk = 1'b0;
  logic        rst;
  logic        req1;
  logic        req0;
  logic        wc;
  logic [1:0]  sz;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] md1;
  logic [31:0] md0;
  logic        rdy1;
  logic        rdy0;
  logic        mis1;
  logic        mis0;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mm [2][1024];
  logic [31:0] last_ld [2];

  always #5 clk = ~clk;

  data_memory_sized #(.DEPTH_LOG2(8), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .write_control(wc), .size(sz),
    .load_unsigned(uns), .address(addr), .wdata(wd),
    .mem_data(md1), .ready(rdy1), .misalign(mis1)
  );

  data_memory_sized #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .write_control(wc), .size(sz),
    .load_unsigned(uns), .address(addr), .wdata(wd),
    .mem_data(md0), .ready(rdy0), .misalign(mis0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic model_illegal(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
  endfunction

  // One complete access on instance 'which'; operands are scrambled once accepted.
  task automatic access(input int which, input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    int          lat;
    int          exp_lat;
    int          nb;
    int          base;
    logic        ill;
    logic [31:0] e;
    wc = w; sz = s; uns = u; addr = a; wd = d;
    if (which == 1) req1 = 1'b1; else req0 = 1'b1;
    @(posedge clk); #1;
    req1 = 1'b0; req0 = 1'b0;
    wc = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom); addr = $urandom; wd = $urandom;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      if (lat == 0) begin
        @(posedge clk); #1;
        if ((which == 1) ? rdy1 : rdy0) lat = n;
      end
    end
    ill = model_illegal(s, a);
    exp_lat = ill ? 1 : ((which == 1) ? 2 : 1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("misalign", {31'd0, (which == 1) ? mis1 : mis0}, {31'd0, ill});
    nb = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    base = int'(a[9:0]);
    if (!ill) begin
      if (w) begin
        for (int k = 0; k < nb; k++) mm[which][base + k] = d[8*k +: 8];
      end else begin
        e = 32'd0;
        for (int k = 0; k < nb; k++) e[8*k +: 8] = mm[which][base + k];
        if (!u && nb == 1) e = {{24{e[7]}}, e[7:0]};
        if (!u && nb == 2) e = {{16{e[15]}}, e[15:0]};
        last_ld[which] = e;
      end
    end
    check("mem_data", (which == 1) ? md1 : md0, last_ld[which]);
    @(posedge clk); #1;
    check("ready_pulse", {31'd0, (which == 1) ? rdy1 : rdy0}, 32'd0);
  endtask

  task automatic quiet_cycles(input string tag);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      check(tag, {31'd0, rdy1}, 32'd0);
    end
  endtask

  task automatic model_reset();
    last_ld[0] = 32'd0;
    last_ld[1] = 32'd0;
`ifdef DMEM_RESET_CLEAR_EN
    for (int i = 0; i < 1024; i++) begin
      mm[0][i] = 8'd0;
      mm[1][i] = 8'd0;
    end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  rs;
    logic [31:0] ra;
    rst = 1'b1; req1 = 1'b0; req0 = 1'b0;
    wc = 1'b0; sz = 2'd0; uns = 1'b0; addr = 32'd0; wd = 32'd0;
    last_ld[0] = 32'd0; last_ld[1] = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_data", md1, 32'd0);
    check("rst_ready", {31'd0, rdy1}, 32'd0);
    check("rst_misalign", {31'd0, mis1}, 32'd0);
    check("rst_mem_data0", md0, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) access(1, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom);

    access(1, 1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678);
    access(1, 1'b0, 2'd2, 1'b1, 32'h10, 32'h0);
    check("word_rd", md1, 32'h12345678);
    access(1, 1'b1, 2'd0, 1'b0, 32'h11, 32'h555555AB);
    access(1, 1'b0, 2'd2, 1'b1, 32'h10, 32'h0);
    check("byte_merge", md1, 32'h1234AB78);
    access(1, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
    check("byte_signed", md1, 32'hFFFFFFAB);
    access(1, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
    check("byte_unsigned", md1, 32'h000000AB);
    access(1, 1'b1, 2'd1, 1'b0, 32'h12, 32'hAAAA8001);
    access(1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
    check("half_signed", md1, 32'hFFFF8001);
    access(1, 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    check("half_unsigned", md1, 32'h00008001);
    access(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    check("half_merge", md1, 32'h8001AB78);
    access(1, 1'b0, 2'd1, 1'b0, 32'h13, 32'h0);
    check("misalign_keep", md1, 32'h8001AB78);
    access(1, 1'b1, 2'd2, 1'b0, 32'h22, 32'hDEADDEAD);
    access(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    access(1, 1'b1, 2'd3, 1'b0, 32'h20, 32'h0BADBAD0);
    access(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

    access(1, 1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D);
    access(1, 1'b0, 2'd2, 1'b0, 32'h000, 32'h0);
    check("wrap1", md1, 32'hCAFEF00D);
    access(0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D);
    access(0, 1'b0, 2'd2, 1'b0, 32'h000, 32'h0);
    check("wrap0", md0, 32'hCAFEF00D);
    access(0, 1'b1, 2'd0, 1'b0, 32'hFFFF_F003, 32'h0000007E);
    access(0, 1'b0, 2'd1, 1'b0, 32'h002, 32'h0);
    access(0, 1'b0, 2'd2, 1'b0, 32'h001, 32'h0);

    // Reset during WAIT aborts a pending store.
    access(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'h11112222);
    wc = 1'b1; sz = 2'd2; uns = 1'b0; addr = 32'h40; wd = 32'hDEADBEEF; req1 = 1'b1;
    @(posedge clk); #1;
    req1 = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("abort_mem_data", md1, 32'd0);
    quiet_cycles("abort_ready");
    access(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);

    // Reset wins over a simultaneous request.
    wc = 1'b1; sz = 2'd2; addr = 32'h44; wd = 32'h0F0F0F0F; req1 = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    req1 = 1'b0; rst = 1'b0;
    model_reset();
    quiet_cycles("rst_prio_ready");
    access(1, 1'b0, 2'd2, 1'b0, 32'h44, 32'h0);

`ifdef DMEM_RESET_CLEAR_EN
    for (int i = 0; i < 256; i++) access(1, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom);
`endif
    for (int i = 0; i < 300; i++) begin
      rs = 2'($urandom_range(0, 3));
      ra = $urandom;
      access(1, 1'($urandom), rs, 1'($urandom), ra, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_sized.md
DATA_MEMORY_SIZED -- requirements
Module: data_memory_sized

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, giving the log2 of the number of 32-bit words (default 256 words / 1 KiB).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, giving the extra access wait states (legal range 0..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, 1 bit: access request, sampled only in IDLE.
REQ-006 SHALL have port write_control, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port size, input, 2 bits: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
REQ-008 SHALL have port load_unsigned, input, 1 bit: 1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-009 SHALL have port address, input, 32 bits: byte address.
REQ-010 SHALL have port wdata, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 SHALL have port mem_data, output, 32 bits: load result, extended to 32 bits.
REQ-012 SHALL have port ready, output, 1 bit: one-cycle pulse marking access completion.
REQ-013 SHALL have port misalign, output, 1 bit: one-cycle pulse, coincident with ready, flagging a rejected access.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, WAIT, DONE.
REQ-015 IDLE with req=1 SHALL latch address, size, write_control, load_unsigned and wdata.
- If the access is legal, go to WAIT when WAIT_CYCLES>0, else to DONE.
REQ-016 WAIT SHALL count down WAIT_CYCLES cycles, then go to DONE; ready is asserted exactly 1+WAIT_CYCLES cycles after the req edge.
REQ-017 DONE SHALL assert ready for one cycle, perform the store or update mem_data, then return to IDLE; a new req is accepted in the cycle after DONE.
REQ-018 req SHALL be ignored in WAIT and DONE; latched operands SHALL NOT change mid-access.
REQ-019 An access SHALL be illegal when size=11, size=01 with address[0]=1, or size=10 with address[1:0]!=0.
REQ-020 An illegal access SHALL go directly to DONE, pulse ready and misalign together one cycle after req, leave memory unwritten and leave mem_data unchanged.
REQ-021 Word index SHALL be address[DEPTH_LOG2+1:2]; higher address bits are ignored, so accesses wrap modulo 4*2^DEPTH_LOG2 bytes.
REQ-022 Byte lanes SHALL be little-endian: byte k of a word lives in bits [8k+7:8k].
- A byte store writes only lane address[1:0].
- A half store writes lanes {address[1],0} and {address[1],1}.
- Unselected lanes are preserved.
REQ-023 Loads SHALL select the same lanes, extend per load_unsigned, and hold mem_data until the next successful load completes.
- Stores do not change mem_data.
REQ-024 A store followed by a load of the same address SHALL return the stored value (no stale read).

Reset
REQ-025 rst=1 at a clock edge SHALL force state IDLE, wait counter 0, mem_data 0, ready 0, misalign 0.
REQ-026 rst asserted mid-access SHALL abort the access; a pending store SHALL NOT be written.
REQ-027 rst SHALL take priority over req in the same cycle.

Configuration
REQ-028 Macro DMEM_RESET_CLEAR_EN defined SHALL zero every memory word while rst=1.
REQ-029 Without DMEM_RESET_CLEAR_EN, memory contents SHALL be preserved across reset and undefined at power-up; all other behaviour is identical.

Verification
REQ-030 WAIT_CYCLES=1, word store 0x12345678 @0x10, then unsigned word load @0x10 -> each access gives ready 2 cycles after req; load gives mem_data=0x12345678, misalign=0.
REQ-031 After REQ-030: byte store 0xAB @0x11, word load @0x10 -> 0x1234AB78; signed byte load @0x11 -> 0xFFFFFFAB; unsigned byte load @0x11 -> 0x000000AB.
REQ-032 Half store 0x8001 @0x12, then signed half load @0x12 -> 0xFFFF8001; unsigned half load -> 0x00008001; word load @0x10 -> 0x8001AB78.
REQ-033 Half load @0x13 or word store @0x22 -> ready+misalign 1 cycle after req; memory and mem_data unchanged.
REQ-034 DEPTH_LOG2=8: word store 0xCAFEF00D @0x400, word load @0x000 -> 0xCAFEF00D (wrap). WAIT_CYCLES=0 -> ready 1 cycle after req.
REQ-035 Store issued then rst pulsed during WAIT -> no write (load returns old value); with DMEM_RESET_CLEAR_EN, any load after reset -> 0x00000000.
